// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 HP-port memory responder.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Only full 64-bit beats are native to this responder.
  localparam logic [2:0] SIZE_64B = 3'b011;

  // Worst-of two responses: DECERR > SLVERR > OKAY (EXOKAY is never produced).
  function automatic resp_e resp_worst(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slv_sdp_ram.sv
// Simple-dual-port 64-bit array: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old word.
module axi_slv_sdp_ram #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wstrb,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [MEM_WORDS];

  // Registered read plus byte-masked write; the read samples pre-write contents.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_hp_slave_mem.sv
// AXI4 memory responder standing in for the PS HP0 port.
// Independent write (AW/W/B) and read (AR/R) engines over a 64-bit SDP array.
// Optional define AXI_SLV_BACKPRESSURE_EN: an LFSR throttles wready and new rvalid.
module axi4_hp_slave_mem
  import axi_slv_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              ID_W      = 4,
  parameter int              MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int                AW          = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

  wstate_e           w_state, w_next;
  rstate_e           r_state, r_next;
  logic              rdy_en;
  logic              bp_w, bp_r;

  logic [ADDR_W-1:0] w_addr, aw_idx;
  logic [7:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  resp_e             w_acc, w_beat_resp, w_acc_nxt;
  logic              aw_hs, w_hs, w_beat_last, w_dec;

  logic [ADDR_W-1:0] r_addr, r_addr_nxt, ar_idx;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_burst;
  resp_e             r_err;
  logic              ar_hs, r_hs, r_pend, r_dec;

  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [63:0]       ram_rdata;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR used as a backpressure pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_w = lfsr[0];
  assign bp_r = lfsr[1];
`else
  assign bp_w = 1'b0;
  assign bp_r = 1'b0;
`endif

  // Readies stay low while reset is held and come up one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Byte address to word index; addresses below BASE_ADDR wrap high and decode as DECERR.
  assign aw_idx = (s_axi_awaddr - BASE_ADDR) >> 3;
  assign ar_idx = (s_axi_araddr - BASE_ADDR) >> 3;

  // ---------------- write channel ----------------
  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_beat_last = (w_cnt == w_len);
  assign w_dec       = (w_addr >= MEM_WORDS_A);
  assign w_beat_resp = w_dec ? DECERR : ((s_axi_wlast != w_beat_last) ? SLVERR : OKAY);
  assign w_acc_nxt   = resp_worst(w_acc, w_beat_resp);

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write FSM next state and handshake outputs; the beat count, not wlast, ends the burst.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = rdy_en;
        if (s_axi_awvalid && rdy_en) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !bp_w;
        if (s_axi_wvalid && !bp_w && w_beat_last) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // B-channel response fields, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_bid   <= '0;
      s_axi_bresp <= 2'b00;
    end else begin
      if (aw_hs)               s_axi_bid   <= s_axi_awid;
      if (w_hs && w_beat_last) s_axi_bresp <= w_acc_nxt;
    end
  end

  // Burst context: address walk, beat count and running worst response.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_addr  <= aw_idx;
      w_len   <= s_axi_awlen;
      w_burst <= s_axi_awburst;
      w_cnt   <= 8'd0;
      w_acc   <= (s_axi_awsize != SIZE_64B || s_axi_awburst != INCR && s_axi_awburst != FIXED)
                 ? SLVERR : OKAY;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      w_acc <= w_acc_nxt;
      if (w_burst == INCR) w_addr <= w_addr + 1'b1;
    end
  end

  // ---------------- read channel ----------------
  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign r_hs       = s_axi_rvalid && s_axi_rready;
  assign r_addr_nxt = (r_burst == INCR) ? r_addr + 1'b1 : r_addr;
  assign r_dec      = (r_addr >= MEM_WORDS_A);
  assign ram_re     = ar_hs || (r_hs && !s_axi_rlast);
  assign ram_raddr  = ar_hs ? ar_idx[AW-1:0] : r_addr_nxt[AW-1:0];

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read FSM next state and arready.
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = rdy_en;
        if (s_axi_arvalid && rdy_en) r_next = R_DATA;
      end
      R_DATA: begin
        if (r_hs && s_axi_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // R-channel beat register: loads once the array word lands, holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
      s_axi_rlast  <= 1'b0;
      s_axi_rid    <= '0;
      r_pend       <= 1'b0;
    end else begin
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        r_pend    <= 1'b1;
      end
      if (r_pend && !bp_r) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= r_dec ? 64'd0 : ram_rdata;
        s_axi_rresp  <= r_dec ? DECERR : r_err;
        s_axi_rlast  <= (r_cnt == r_len);
        r_pend       <= 1'b0;
      end else if (r_hs) begin
        s_axi_rvalid <= 1'b0;
        if (!s_axi_rlast) r_pend <= 1'b1;
      end
    end
  end

  // Read burst context: current beat address and count.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_addr  <= ar_idx;
      r_len   <= s_axi_arlen;
      r_burst <= s_axi_arburst;
      r_cnt   <= 8'd0;
      r_err   <= (s_axi_arsize != SIZE_64B || s_axi_arburst != INCR && s_axi_arburst != FIXED)
                 ? SLVERR : OKAY;
    end else if (r_hs) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  axi_slv_sdp_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (w_hs && !w_dec),
    .waddr (w_addr[AW-1:0]),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_hp_slave_mem.sv
// Directed bench for axi4_hp_slave_mem with B/R scoreboards and a word-level memory model.
module tb_axi4_hp_slave_mem;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [1:0]  B_FIXED = 2'd0, B_INCR = 2'd1, B_WRAP = 2'd2;
  localparam logic [1:0]  R_OKAY = 2'd0, R_SLVERR = 2'd2, R_DECERR = 2'd3;
  localparam logic [2:0]  SZ64 = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = SZ64, arsize = SZ64;
  logic [1:0]  awburst = B_INCR, arburst = B_INCR, bresp, rresp;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;
  logic [63:0] wdata = '0, rdata;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [63:0] model [int];
  int          n_checks = 0;
  int          n_fail = 0;

  axi4_hp_slave_mem #(
    .ADDR_W(32), .ID_W(4), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [63:0] d0,
                          input logic [7:0] strb, input int lastpos, input logic [1:0] exp_resp);
    int    idx;
    int    t;
    bexp_t e;
    logic [63:0] d;
    b_q.push_back('{resp: exp_resp, id: id});
    idx = int'((addr - BASE) >> 3);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge clk); t++; end
    check("awready wait", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = d0 + 64'(i);
      wvalid = 1'b1; wdata = d; wstrb = strb; wlast = (i == lastpos);
      t = 0;
      while (!wready && t < 200) begin @(negedge clk); t++; end
      if (!wready) check("wready wait", {63'd0, wready}, 64'd1);
      if (idx < MEM_WORDS) begin
        for (int k = 0; k < 8; k++) if (strb[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
      if (burst == B_INCR) idx++;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 200) begin @(negedge clk); t++; end
    e = b_q.pop_front();
    check("bvalid", {63'd0, bvalid}, 64'd1);
    check("bresp", {62'd0, bresp}, {62'd0, e.resp});
    check("bid", {60'd0, bid}, {60'd0, e.id});
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int stall_beat, input int stall_cycles);
    int    idx;
    int    t;
    rexp_t e;
    idx = int'((addr - BASE) >> 3);
    for (int b = 0; b <= len; b++) begin
      e.data = (idx + b >= MEM_WORDS) ? 64'd0 : model[idx + b];
      e.resp = (idx + b >= MEM_WORDS) ? R_DECERR : R_OKAY;
      e.last = (b == len);
      e.id   = id;
      r_q.push_back(e);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arburst = B_INCR; arsize = SZ64; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge clk); t++; end
    check("arready wait", {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      rready = (b != stall_beat);
      t = 0;
      while (!rvalid && t < 200) begin @(negedge clk); t++; end
      check("rvalid", {63'd0, rvalid}, 64'd1);
      if (b == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          check("stall rvalid", {63'd0, rvalid}, 64'd1);
          check("stall rdata", rdata, r_q[0].data);
          check("stall rlast", {63'd0, rlast}, {63'd0, r_q[0].last});
          @(negedge clk);
        end
        rready = 1'b1;
      end
      e = r_q.pop_front();
      check("rdata", rdata, e.data);
      check("rresp", {62'd0, rresp}, {62'd0, e.resp});
      check("rlast", {63'd0, rlast}, {63'd0, e.last});
      check("rid", {60'd0, rid}, {60'd0, e.id});
      @(negedge clk);
    end
    rready = 1'b0;
    repeat (3) @(negedge clk);
    check("no extra beat", {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst awready", {63'd0, awready}, 64'd0);
    check("rst wready", {63'd0, wready}, 64'd0);
    check("rst bvalid", {63'd0, bvalid}, 64'd0);
    check("rst arready", {63'd0, arready}, 64'd0);
    check("rst rvalid", {63'd0, rvalid}, 64'd0);
    check("rst bid", {60'd0, bid}, 64'd0);
    check("rst bresp", {62'd0, bresp}, 64'd0);
    check("rst rid", {60'd0, rid}, 64'd0);
    check("rst rresp", {62'd0, rresp}, 64'd0);
    check("rst rdata", rdata, 64'd0);
    check("rst rlast", {63'd0, rlast}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-beat INCR write then read back with matching id.
    do_write(4'h5, 32'h100, 7, B_INCR, SZ64, 64'd0, 8'hFF, 7, R_OKAY);
    do_read(4'h5, 32'h100, 7, -1, 0);

    // Byte-strobe merge.
    do_write(4'h1, 32'h0, 0, B_INCR, SZ64, 64'h1122_3344_5566_7788, 8'hFF, 0, R_OKAY);
    do_write(4'h1, 32'h0, 0, B_INCR, SZ64, 64'h0000_0000_FFFF_FFFF, 8'h0F, 0, R_OKAY);
    do_read(4'h1, 32'h0, 0, -1, 0);
    check("strobe merge model", model[0], 64'h1122_3344_FFFF_FFFF);

    // Read backpressure held for 5 cycles on beat 1.
    do_read(4'h2, 32'h100, 3, 1, 5);

    // Burst crossing the top of memory.
    do_write(4'h3, MEM_WORDS * 8 - 8, 1, B_INCR, SZ64, 64'hA5A5_0000_0000_0000, 8'hFF, 1, R_DECERR);
    do_read(4'h3, MEM_WORDS * 8 - 8, 1, -1, 0);

    // Early wlast, WRAP burst, unsupported size.
    do_write(4'h4, 32'h200, 3, B_INCR, SZ64, 64'h40, 8'hFF, 2, R_SLVERR);
    do_read(4'h4, 32'h200, 3, -1, 0);
    do_write(4'h6, 32'h300, 3, B_WRAP, SZ64, 64'h60, 8'hFF, 3, R_SLVERR);
    do_read(4'h6, 32'h300, 0, -1, 0);
    do_write(4'h7, 32'h400, 0, B_FIXED, 3'b010, 64'h77, 8'hFF, 0, R_SLVERR);

    // Reset in the middle of a write burst.
    @(negedge clk);
    awid = 4'h8; awaddr = 32'h800; awlen = 8'd7; awburst = B_INCR; awsize = SZ64; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wstrb = 8'hFF; wdata = 64'hDEAD;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst awready", {63'd0, awready}, 64'd0);
    check("mid rst wready", {63'd0, wready}, 64'd0);
    check("mid rst bvalid", {63'd0, bvalid}, 64'd0);
    check("mid rst arready", {63'd0, arready}, 64'd0);
    check("mid rst rvalid", {63'd0, rvalid}, 64'd0);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_write(4'h9, 32'hA00, 1, B_INCR, SZ64, 64'h9000, 8'hFF, 1, R_OKAY);
    do_read(4'h9, 32'hA00, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
